riscv_div_seq: RTL and testbench

Multi-cycle iterative divider sequencer for the RV32 execute stage, implementing DIV, DIVU, REM and REMU.
- Accepts one operation when the EX-stage instruction is a divide.
- Holds the hazard unit in stall via o_busy until the result is ready.
- Returns a one-cycle o_done pulse with the result, which the EX result mux selects in place of the ALU result.
- Uses a restoring radix-2 algorithm, one quotient bit per cycle.

---
 rtl/riscv_div_seq.sv | 168 ++++++++++++++++
 tb/tb_riscv_div_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_div_seq
//  Purpose  : Iterative restoring radix-2 divider (DIV/DIVU/REM/REMU) for the
//             RV32 execute stage, one quotient bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_flush,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [WIDTH-1:0] c_min  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH-1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_busy;

   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic [1:0]         r_op;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_result;

   // Operand conditioning at accept time
   logic               w_signed;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_abs;
   logic [WIDTH-1:0]   w_b_abs;
   logic               w_div0;
   logic               w_ovf;
   logic               w_special;
   logic [WIDTH-1:0]   w_special_res;

   assign w_signed      = ~i_op[0];
   assign w_a_neg       = w_signed & i_dividend[WIDTH-1];
   assign w_b_neg       = w_signed & i_divisor[WIDTH-1];
   assign w_a_abs       = w_a_neg ? (~i_dividend + 1'b1) : i_dividend;
   assign w_b_abs       = w_b_neg ? (~i_divisor + 1'b1) : i_divisor;
   assign w_div0        = (i_divisor == '0);
   assign w_ovf         = w_signed & (i_dividend == c_min) & (i_divisor == '1);
   assign w_special     = w_div0 | w_ovf;
   assign w_special_res = w_div0 ? (i_op[1] ? i_dividend : '1)
                                 : (i_op[1] ? '0 : c_min);

   // One restoring step: the partial remainder gains the next dividend bit
   logic [WIDTH:0]     w_rem_sh;
   logic               w_ge;
   logic [WIDTH-1:0]   w_sub;

   assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});
   assign w_sub    = w_rem_sh[WIDTH-1:0] - r_div;

   // Sign fix-up and result selection
   logic               w_fix_signed;
   logic [WIDTH-1:0]   w_q_fix;
   logic [WIDTH-1:0]   w_r_fix;
   logic [WIDTH-1:0]   w_fix_res;

   assign w_fix_signed = ~r_op[0];
   assign w_q_fix      = (w_fix_signed & r_neg_q) ? (~r_quo + 1'b1) : r_quo;
   assign w_r_fix      = (w_fix_signed & r_neg_r) ? (~r_rem + 1'b1) : r_rem;
   assign w_fix_res    = r_op[1] ? w_r_fix : w_q_fix;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_flush) begin
               w_accept    = 1'b1;
               w_busy      = 1'b1;
               w_state_nxt = w_special ? S_DONE : S_BUSY;
            end
         end
         S_BUSY: begin
            w_busy = 1'b1;
            if (r_cnt == c_last) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX: begin
            w_busy      = 1'b1;
            w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (i_flush) begin
         w_state_nxt = S_IDLE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_op     <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_rem   <= '0;
         r_quo   <= w_a_abs;
         r_div   <= w_b_abs;
         r_op    <= i_op;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         if (w_special) begin
            r_result <= w_special_res;
         end
      end else if (!i_flush && r_state == S_BUSY) begin
         r_rem <= w_ge ? w_sub : w_rem_sh[WIDTH-1:0];
         r_quo <= {r_quo[WIDTH-2:0], w_ge};
         r_cnt <= r_cnt + 1'b1;
      end else if (!i_flush && r_state == S_FIX) begin
         r_result <= w_fix_res;
      end
   end

   // Gated by reset so a held i_start cannot request a stall during reset
   assign o_busy   = w_busy & i_rstn;
   assign o_done   = (r_state == S_DONE);
   assign o_result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_riscv_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_div_seq
//  Purpose  : Self-checking bench for riscv_div_seq against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_div_seq;

   localparam int W = 32;

   logic          clk;
   logic          rstn;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          flush;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;

   int tests;
   int fails;

   riscv_div_seq #(.WIDTH(W)) dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_start    (start),
      .i_op       (op),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .i_flush    (flush),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // RISC-V M-extension semantics straight from the ISA rules
   function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      int sa;
      int sb;
      if (b == 0) return o[1] ? a : '1;
      if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
         sa = $signed(a);
         sb = $signed(b);
         return o[1] ? W'(sa % sb) : W'(sa / sb);
      end
      return o[1] ? (a % b) : (a / b);
   endfunction

   function automatic int latency(input logic [1:0] o, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
      if (b == 0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return W + 2;
   endfunction

   // Issue one op at a negedge, then count cycles until o_done
   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noise);
      int n;
      int lat;
      bit busy_ok;
      logic [W-1:0] exp;
      exp = model(o, a, b);
      lat = latency(o, a, b);
      @(negedge clk);
      start = 1'b1; op = o; dividend = a; divisor = b;
      #1;
      check({tag, "_busy_issue"}, W'(busy), W'(1));
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      busy_ok = 1'b1;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (done) break;
         if (!busy) busy_ok = 1'b0;
         if (noise) begin
            start    = 1'($urandom);
            dividend = $urandom;
            divisor  = $urandom;
            op       = 2'($urandom);
         end
      end
      start = 1'b0;
      check({tag, "_done_seen"}, W'(done), W'(1));
      check({tag, "_latency"}, W'(n), W'(lat));
      check({tag, "_busy_hold"}, W'(busy_ok), W'(1));
      check({tag, "_busy_at_done"}, W'(busy), W'(0));
      check({tag, "_result"}, result, exp);
      @(negedge clk);
      check({tag, "_done_pulse"}, W'(done), W'(0));
      check({tag, "_result_hold"}, result, exp);
   endtask

   initial begin
      logic [W-1:0] prior;
      logic [1:0]   ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      bit           gone;
      tests = 0; fails = 0;
      rstn = 1'b0; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0; flush = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_busy", W'(busy), W'(0));
      check("reset_done", W'(done), W'(0));
      check("reset_result", result, '0);
      rstn = 1'b1;
      @(negedge clk);

      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
      run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 1'b0);
      run_op("rem_5_0",    2'b10, 32'd5, 32'd0, 1'b0);
      run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("divu_max",   2'b01, 32'hFFFF_FFFF, 32'd1, 1'b0);

      // Flush part way through an op
      prior = result;
      @(negedge clk);
      start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", W'(busy), W'(0));
      check("flush_done", W'(done), W'(0));
      gone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) gone = 1'b1;
      end
      check("flush_no_done", W'(gone), W'(0));
      check("flush_result_kept", result, prior);
      run_op("divu_9_3_after_flush", 2'b01, 32'd9, 32'd3, 1'b0);

      // Input noise during BUSY must not disturb the latched op
      run_op("noise_divu", 2'b01, 32'd1000, 32'd13, 1'b1);
      run_op("noise_div",  2'b00, 32'hFFFF_F000, 32'd77, 1'b1);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = $urandom_range(1, 15);
            3: rb = -$urandom_range(1, 15);
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0);
      end

      // Asynchronous reset between edges in the middle of BUSY
      @(negedge clk);
      start = 1'b1; op = 2'b01; dividend = 32'd123; divisor = 32'd4;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("async_rst_busy", W'(busy), W'(0));
      check("async_rst_done", W'(done), W'(0));
      check("async_rst_result", result, '0);
      @(negedge clk);
      rstn = 1'b1;
      gone = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) gone = 1'b1;
      end
      check("async_rst_no_done", W'(gone), W'(0));
      check("async_rst_result_kept", result, '0);
      run_op("after_reset", 2'b01, 32'd123, 32'd4, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
